// File: rtl/mopshub_arb_pkg.sv
// Shared definitions for the hub bus arbiters.
// Contents:
//   N_BUS, SEL_W  - number of arbitrated sources and the width of their select.
//   arb_state_t   - 2-bit arbiter state encoding.
//   bus_onehot()  - converts a select index into a one-hot grant vector.
package mopshub_arb_pkg;

    localparam int N_BUS = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    function automatic logic [N_BUS-1:0] bus_onehot(input logic [SEL_W-1:0] idx);
        return N_BUS'(1) << idx;
    endfunction

endpackage

// File: rtl/bus_scan_arbiter_if.sv
// Request/grant bundle between the bus sources, the consumer and bus_scan_arbiter.
// Signals:
//   req[7:0]     per-bus level request
//   done         consumer pulse: current transfer finished
//   sel[2:0]     select for the downstream registered 8:1 mux
//   grant[7:0]   one-hot grant, zero when nothing is granted
//   sel_valid    mux output currently reflects the granted bus
//   busy         arbiter is in a grant cycle
//   timeout_err  1-cycle pulse on a forced release
// Modports:
//   master - requester/consumer side (drives req and done)
//   slave  - arbiter side
interface bus_scan_arbiter_if;
    import mopshub_arb_pkg::*;

    logic [N_BUS-1:0] req;
    logic             done;
    logic [SEL_W-1:0] sel;
    logic [N_BUS-1:0] grant;
    logic             sel_valid;
    logic             busy;
    logic             timeout_err;

    modport master (
        output req,
        output done,
        input  sel,
        input  grant,
        input  sel_valid,
        input  busy,
        input  timeout_err
    );

    modport slave (
        input  req,
        input  done,
        output sel,
        output grant,
        output sel_valid,
        output busy,
        output timeout_err
    );

endinterface

// File: rtl/bus_scan_arbiter_rr_prio_enc8.sv
// rr_prio_enc8: combinational rotate-search priority encoder.
// Finds the first set request bit starting at (last+1) mod 8 and searching
// upward with wrap-around. Shared by several hub arbiters.
// Ports:
//   req[7:0]   in   request vector
//   last[2:0]  in   index granted most recently
//   idx[2:0]   out  winning index (0 when nothing is found)
//   found      out  at least one request is set
module rr_prio_enc8
    import mopshub_arb_pkg::*;
(
    input  logic [N_BUS-1:0] req,
    input  logic [SEL_W-1:0] last,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    // pos[gi] is the bus index visited at step gi of the search; rot[gi] is
    // its request bit. The 3-bit add wraps naturally, giving mod-8 rotation.
    logic [SEL_W-1:0] pos [N_BUS];
    logic [N_BUS-1:0] rot;

    genvar gi;
    generate
        for (gi = 0; gi < N_BUS; gi++) begin : g_rot
            assign pos[gi] = last + SEL_W'(gi) + SEL_W'(1);
            assign rot[gi] = req[pos[gi]];
        end
    endgenerate

    assign found = |req;

    // Scan from the far end so the lowest search step wins.
    always_comb begin
        idx = '0;
        for (int i = N_BUS - 1; i >= 0; i--) begin
            if (rot[i]) begin
                idx = pos[i];
            end
        end
    end

endmodule

// File: rtl/bus_scan_arbiter.sv
// bus_scan_arbiter: round-robin arbiter for 8 bus sources feeding a
// registered 8:1 mux (mux8_Nbit). A grant is held until the consumer
// signals done, the requester withdraws, or TIMEOUT active cycles elapse.
// One SETTLE cycle covers the mux register latency before sel_valid rises.
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous reset, active-high
//   bus   slave side of bus_scan_arbiter_if (req, done in; sel, grant,
//         sel_valid, busy, timeout_err out)
// Parameters:
//   N_BUS, SEL_W  fixed at 8 / 3 to match the mux
//   TIMEOUT       max ACTIVE cycles per grant, must be >= 2
//   TMO_W         counter width, 2**TMO_W must exceed TIMEOUT
module bus_scan_arbiter
    import mopshub_arb_pkg::*;
#(
    parameter int TIMEOUT = 1000,
    parameter int TMO_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    bus_scan_arbiter_if.slave    bus
);

    arb_state_t       state_reg;
    arb_state_t       state_next;
    logic [SEL_W-1:0] sel_reg;
    logic [N_BUS-1:0] grant_reg;
    logic [SEL_W-1:0] last_reg;
    logic [TMO_W-1:0] cnt_reg;
    logic             tmo_err_reg;

    logic [SEL_W-1:0] win_idx;
    logic             win_found;

    logic             tmo_reached;
    logic             grant_load;
    logic             grant_drop;
    logic             tmo_fire;

    rr_prio_enc8 u_enc (
        .req   (bus.req),
        .last  (last_reg),
        .idx   (win_idx),
        .found (win_found)
    );

    assign tmo_reached = (cnt_reg == TMO_W'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (win_found) begin
                    state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                state_next = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (bus.done || !bus.req[sel_reg] || tmo_reached) begin
                    state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output / control decode
    always_comb begin
        bus.sel_valid = (state_reg == ST_ACTIVE);
        bus.busy      = (state_reg != ST_IDLE);
        grant_load    = (state_reg == ST_IDLE) && win_found;
        grant_drop    = (state_reg == ST_ACTIVE) && (state_next == ST_RELEASE);
        // done takes precedence over an expiring timer.
        tmo_fire      = (state_reg == ST_ACTIVE) && tmo_reached && !bus.done;
    end

    // Grant datapath. sel is deliberately kept after release so the mux
    // keeps pointing at the last served bus until the next grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_reg     <= '0;
            grant_reg   <= '0;
            last_reg    <= SEL_W'(N_BUS - 1);
            tmo_err_reg <= 1'b0;
        end else begin
            if (grant_load) begin
                sel_reg   <= win_idx;
                grant_reg <= bus_onehot(win_idx);
            end else if (grant_drop) begin
                grant_reg <= '0;
            end
            if (state_reg == ST_RELEASE) begin
                last_reg <= sel_reg;
            end
            // Pulse lands in the RELEASE cycle that the timeout forced.
            tmo_err_reg <= tmo_fire;
        end
    end

    // Active-cycle counter. It only advances while the grant stays ACTIVE,
    // so it peaks at TIMEOUT-1 and never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            if (state_reg == ST_RELEASE) begin
                cnt_reg <= '0;
            end else if ((state_reg == ST_ACTIVE) && (state_next == ST_ACTIVE)) begin
                cnt_reg <= cnt_reg + TMO_W'(1);
            end
        end
    end

    assign bus.sel         = sel_reg;
    assign bus.grant       = grant_reg;
    assign bus.timeout_err = tmo_err_reg;

endmodule

// File: tb/tb_bus_scan_arbiter.sv
// Testbench for bus_scan_arbiter with a behavioural registered 8:1 mux.
// Expected grant indices are queued when stimulus is applied and popped by a
// monitor whenever a new grant appears.
module tb_bus_scan_arbiter;

    logic clk;
    logic rst;

    bus_scan_arbiter_if bif ();

    bus_scan_arbiter #(
        .TIMEOUT (8),
        .TMO_W   (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_err;
    int exp_q [$];
    int cyc;
    int last_grant_cyc;
    bit spacing_on;
    int tmo_pulses;
    logic [7:0] prev_grant;
    logic [7:0] data_tbl [8];
    logic [7:0] mux_out;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Behavioural mux8_Nbit: one register stage on the selected input.
    always @(posedge clk) mux_out <= data_tbl[bif.sel];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: scoreboard pop on each new grant, integration check while valid.
    always @(negedge clk) begin
        int e;
        if (bif.timeout_err) tmo_pulses++;
        if (bif.grant != 8'h00 && prev_grant == 8'h00) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_grant", 32'(bif.grant), 32'h0);
            end else begin
                e = exp_q.pop_front();
                chk("grant_sel", 32'(bif.sel), 32'(e));
                chk("grant_onehot", 32'(bif.grant), 32'(1) << e);
                $display("grant bus %0d at cycle %0d", bif.sel, cyc);
                if (spacing_on && last_grant_cyc >= 0)
                    chk("rr_spacing", 32'(cyc - last_grant_cyc), 32'd4);
                last_grant_cyc = cyc;
            end
        end
        if (bif.sel_valid)
            chk("mux_data", 32'(mux_out), 32'(data_tbl[bif.sel]));
        prev_grant = bif.grant;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_sb_empty(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) chk("sb_wait_expired", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (bif.busy && n < budget) begin
            step();
            n++;
        end
        chk("idle_reached", 32'(bif.busy), 32'd0);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!bif.sel_valid && n < budget) begin
            step();
            n++;
        end
        chk("valid_reached", 32'(bif.sel_valid), 32'd1);
    endtask

    initial begin
        int t0;
        int alen;
        n_checks = 0;
        n_err = 0;
        cyc = 0;
        last_grant_cyc = -1;
        spacing_on = 1'b0;
        tmo_pulses = 0;
        prev_grant = 8'h00;
        for (int i = 0; i < 8; i++) data_tbl[i] = 8'hA0 + 8'(i * 3);
        rst = 1'b1;
        bif.req = 8'h00;
        bif.done = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_sel", 32'(bif.sel), 32'd0);
        chk("rst_grant", 32'(bif.grant), 32'd0);
        chk("rst_sel_valid", 32'(bif.sel_valid), 32'd0);
        chk("rst_busy", 32'(bif.busy), 32'd0);
        chk("rst_timeout_err", 32'(bif.timeout_err), 32'd0);
        rst = 1'b0;
        step();

        // Round-robin, all requesting, done held
        spacing_on = 1'b1;
        last_grant_cyc = -1;
        bif.done = 1'b1;
        bif.req = 8'hFF;
        for (int i = 0; i < 8; i++) exp_q.push_back(i);
        exp_q.push_back(0);
        wait_sb_empty(200);
        bif.req = 8'h00;
        spacing_on = 1'b0;
        wait_idle(20);
        bif.done = 1'b0;
        step();

        // Single bus, exact timing
        bif.req = 8'h04;
        exp_q.push_back(2);
        @(posedge clk);
        #1;
        chk("sb_sel_p1", 32'(bif.sel), 32'd2);
        chk("sb_grant_p1", 32'(bif.grant), 32'h04);
        chk("sb_valid_p1", 32'(bif.sel_valid), 32'd0);
        chk("sb_busy_p1", 32'(bif.busy), 32'd1);
        @(posedge clk);
        #1;
        chk("sb_valid_p2", 32'(bif.sel_valid), 32'd1);
        step();
        bif.done = 1'b1;
        @(posedge clk);
        #1;
        chk("sb_rel_grant", 32'(bif.grant), 32'h00);
        chk("sb_rel_sel", 32'(bif.sel), 32'd2);
        chk("sb_rel_valid", 32'(bif.sel_valid), 32'd0);
        chk("sb_rel_tmo", 32'(bif.timeout_err), 32'd0);
        step();
        bif.done = 1'b0;
        bif.req = 8'h00;
        wait_idle(20);

        // Wrap: last=6 then req=41 -> 0 then 6
        bif.done = 1'b1;
        bif.req = 8'h40;
        exp_q.push_back(6);
        wait_sb_empty(20);
        bif.req = 8'h41;
        exp_q.push_back(0);
        exp_q.push_back(6);
        wait_sb_empty(40);
        bif.req = 8'h00;
        wait_idle(20);
        bif.done = 1'b0;
        step();

        // Timeout on bus 4, then re-grant ended by done on the timeout cycle
        t0 = tmo_pulses;
        bif.req = 8'h10;
        exp_q.push_back(4);
        exp_q.push_back(4);
        wait_valid(20);
        alen = 1;
        for (int n = 0; n < 50; n++) begin
            step();
            if (!bif.sel_valid) break;
            alen++;
        end
        chk("tmo_active_len", 32'(alen), 32'd8);
        chk("tmo_pulse_now", 32'(bif.timeout_err), 32'd1);
        chk("tmo_grant_rel", 32'(bif.grant), 32'd0);
        chk("tmo_pulse_count", 32'(tmo_pulses - t0), 32'd1);
        wait_valid(20);
        repeat (7) step();
        chk("dwt_still_valid", 32'(bif.sel_valid), 32'd1);
        t0 = tmo_pulses;
        bif.done = 1'b1;
        step();
        bif.done = 1'b0;
        bif.req = 8'h00;
        chk("dwt_grant_rel", 32'(bif.grant), 32'd0);
        chk("dwt_no_tmo", 32'(bif.timeout_err), 32'd0);
        wait_idle(20);
        chk("dwt_pulse_count", 32'(tmo_pulses - t0), 32'd0);
        wait_sb_empty(5);

        // Withdrawal of bus 3
        t0 = tmo_pulses;
        bif.req = 8'h08;
        exp_q.push_back(3);
        wait_valid(20);
        step();
        step();
        bif.req = 8'h00;
        step();
        chk("wd_grant", 32'(bif.grant), 32'd0);
        chk("wd_busy", 32'(bif.busy), 32'd1);
        chk("wd_valid", 32'(bif.sel_valid), 32'd0);
        chk("wd_tmo", 32'(bif.timeout_err), 32'd0);
        chk("wd_sel", 32'(bif.sel), 32'd3);
        wait_idle(20);
        chk("wd_pulse_count", 32'(tmo_pulses - t0), 32'd0);

        // Asynchronous reset during ACTIVE
        t0 = tmo_pulses;
        bif.req = 8'hFF;
        exp_q.push_back(4);
        wait_valid(20);
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_sel", 32'(bif.sel), 32'd0);
        chk("arst_grant", 32'(bif.grant), 32'd0);
        chk("arst_valid", 32'(bif.sel_valid), 32'd0);
        chk("arst_busy", 32'(bif.busy), 32'd0);
        chk("arst_tmo", 32'(bif.timeout_err), 32'd0);
        exp_q.push_back(0);
        step();
        rst = 1'b0;
        wait_sb_empty(20);
        bif.req = 8'h00;
        wait_idle(20);
        chk("arst_pulse_count", 32'(tmo_pulses - t0), 32'd0);

        chk("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
